// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-game datapath: button width, FSM codes
// and the one-hot test also used by the downstream comparator.
package jogo_pkg;

   localparam int W_CHAVES = 4;

   typedef enum logic [3:0] {
      ESPERA      = 4'h0,
      DEB_PRESS   = 4'h1,
      PRESSIONADO = 4'h2,
      DEB_SOLTA   = 4'h3
   } estado_t;

   // Clearing the lowest set bit leaves zero only when a single bit was set.
   function automatic logic eh_one_hot(input logic [W_CHAVES-1:0] valor);
      logic [W_CHAVES-1:0] sem_lsb;
      sem_lsb = valor & (valor - {{(W_CHAVES-1){1'b0}}, 1'b1});
      return (valor != {W_CHAVES{1'b0}}) && (sem_lsb == {W_CHAVES{1'b0}});
   endfunction

endpackage

// File: rtl/detector_jogada_if.sv
// Button-bank / play-event bundle between the game controller and detector_jogada.
interface detector_jogada_if;
   import jogo_pkg::*;

   logic                habilita;
   logic                limpa;
   logic [W_CHAVES-1:0] chaves;
   logic [W_CHAVES-1:0] jogada;
   logic                jogada_valida;
   logic                jogada_feita;
   logic [3:0]          db_estado;

   modport slave (
      input  habilita, limpa, chaves,
      output jogada, jogada_valida, jogada_feita, db_estado
   );

   modport master (
      output habilita, limpa, chaves,
      input  jogada, jogada_valida, jogada_feita, db_estado
   );

endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (buttons, iniciar).
module sincronizador_2ff #(
   parameter int LARGURA = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] entrada,
   output logic [LARGURA-1:0] saida
);

   logic [LARGURA-1:0] estagio1_r;
   logic [LARGURA-1:0] estagio2_r;

   // Metastability filter: the second stage is the only one consumers see.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estagio1_r <= {LARGURA{1'b0}};
         estagio2_r <= {LARGURA{1'b0}};
      end else begin
         estagio1_r <= entrada;
         estagio2_r <= estagio1_r;
      end
   end

   assign saida = estagio2_r;

endmodule

// File: rtl/detector_jogada.sv
// Button front-end: synchronise, debounce and turn each press/release into a
// single registered play plus a one-cycle jogada_feita event.
module detector_jogada
   import jogo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic               clock,
   input logic               reset,
   detector_jogada_if.slave  bus
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_UM   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [W_CHAVES-1:0] SEM_TECLA = {W_CHAVES{1'b0}};

   localparam logic [3:0] S_ESPERA      = ESPERA;
   localparam logic [3:0] S_DEB_PRESS   = DEB_PRESS;
   localparam logic [3:0] S_PRESSIONADO = PRESSIONADO;
   localparam logic [3:0] S_DEB_SOLTA   = DEB_SOLTA;

   logic [W_CHAVES-1:0] chaves_sinc_s;
   logic [3:0]          estado_r;
   logic [3:0]          estado_prox_s;
   logic [CNT_W-1:0]    contador_r;
   logic [CNT_W-1:0]    contador_prox_s;
   logic [CNT_W-1:0]    contador_inc_s;
   logic [W_CHAVES-1:0] amostra_r;
   logic [W_CHAVES-1:0] amostra_prox_s;
   logic                aceita_s;
   logic [W_CHAVES-1:0] jogada_r;
   logic                jogada_valida_r;
   logic                jogada_feita_r;

   sincronizador_2ff #(
      .LARGURA (W_CHAVES)
   ) u_sinc_chaves (
      .clock   (clock),
      .reset   (reset),
      .entrada (bus.chaves),
      .saida   (chaves_sinc_s)
   );

   // Saturating increment so the counter can never wrap back to zero.
   always_comb begin
      if (contador_r == CNT_MAX) begin
         contador_inc_s = contador_r;
      end else begin
         contador_inc_s = contador_r + CNT_UM;
      end
   end

   // Next-state logic for the press/release debounce FSM.
   always_comb begin
      estado_prox_s   = estado_r;
      contador_prox_s = contador_r;
      amostra_prox_s  = amostra_r;
      aceita_s        = 1'b0;
      case (estado_r)
         S_ESPERA: begin
            if (bus.habilita && (chaves_sinc_s != SEM_TECLA)) begin
               amostra_prox_s  = chaves_sinc_s;
               contador_prox_s = CNT_ZERO;
               estado_prox_s   = S_DEB_PRESS;
            end else begin
               estado_prox_s   = S_ESPERA;
            end
         end
         S_DEB_PRESS: begin
            // Disabling mid-debounce aborts, so acceptance always sees habilita = 1.
            if (!bus.habilita || (chaves_sinc_s == SEM_TECLA)) begin
               estado_prox_s   = S_ESPERA;
            end else if (chaves_sinc_s != amostra_r) begin
               amostra_prox_s  = chaves_sinc_s;
               contador_prox_s = CNT_ZERO;
            end else if (contador_r == CNT_MAX) begin
               aceita_s        = 1'b1;
               estado_prox_s   = S_PRESSIONADO;
            end else begin
               contador_prox_s = contador_inc_s;
            end
         end
         S_PRESSIONADO: begin
            if (chaves_sinc_s == SEM_TECLA) begin
               contador_prox_s = CNT_ZERO;
               estado_prox_s   = S_DEB_SOLTA;
            end else begin
               estado_prox_s   = S_PRESSIONADO;
            end
         end
         S_DEB_SOLTA: begin
            if (chaves_sinc_s != SEM_TECLA) begin
               estado_prox_s   = S_PRESSIONADO;
            end else if (contador_r == CNT_MAX) begin
               estado_prox_s   = S_ESPERA;
            end else begin
               contador_prox_s = contador_inc_s;
            end
         end
         default: begin
            contador_prox_s = CNT_ZERO;
            estado_prox_s   = S_ESPERA;
         end
      endcase
   end

   // FSM state, debounce counter and captured sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_r   <= S_ESPERA;
         contador_r <= CNT_ZERO;
         amostra_r  <= SEM_TECLA;
      end else begin
         estado_r   <= estado_prox_s;
         contador_r <= contador_prox_s;
         amostra_r  <= amostra_prox_s;
      end
   end

   // Play registers: an acceptance on the same edge as limpa keeps the new play.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         jogada_r        <= SEM_TECLA;
         jogada_valida_r <= 1'b0;
         jogada_feita_r  <= 1'b0;
      end else begin
         jogada_feita_r <= aceita_s;
         if (aceita_s) begin
            jogada_r        <= amostra_r;
            jogada_valida_r <= eh_one_hot(amostra_r);
         end else if (bus.limpa) begin
            jogada_r        <= SEM_TECLA;
            jogada_valida_r <= 1'b0;
         end else begin
            jogada_r        <= jogada_r;
            jogada_valida_r <= jogada_valida_r;
         end
      end
   end

   assign bus.jogada        = jogada_r;
   assign bus.jogada_valida = jogada_valida_r;
   assign bus.jogada_feita  = jogada_feita_r;
   assign bus.db_estado     = estado_r;

endmodule
